// File: rtl/floppy_pkg.sv
// ---------------------------------------------------------------------------
// floppy_pkg
// Shared definitions for the floppy SDRAM byte-window responder.
//   - fsp_state_e : state encoding for floppy_sdram_port
//                   (FSP_IDLE, FSP_REQ, FSP_RWAIT, FSP_HIT)
//   - lane-select constants and helpers:
//       * lane_be()   : lane -> one-hot byte enable
//       * lane_byte() : selects a byte lane from a 16-bit word
// ---------------------------------------------------------------------------
package floppy_pkg;

    typedef enum logic [1:0] {
        FSP_IDLE  = 2'd0,
        FSP_REQ   = 2'd1,
        FSP_RWAIT = 2'd2,
        FSP_HIT   = 2'd3
    } fsp_state_e;

    // addr[0] picks the byte lane inside a 16-bit SDRAM word
    localparam logic       LANE_LO = 1'b0;
    localparam logic       LANE_HI = 1'b1;
    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_BOTH = 2'b11;

    function automatic logic [1:0] lane_be(input logic lane);
        return (lane == LANE_HI) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
        return (lane == LANE_HI) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/fsp_word_cache.sv
// ---------------------------------------------------------------------------
// fsp_word_cache
// One-word read cache (tag, data word, valid) for floppy_sdram_port.
// Ports:
//   clk, srst_i          : clock, synchronous active-high reset
//   lookup_addr_i        : word address to test -> hit_o, word_o (cached word)
//   fill_en_i/_addr/_data: load a complete word and mark it valid
//   wr_en_i/_addr/_lane/_byte : write-through update of one byte lane when
//                          the word address matches the tag
//   inval_i              : clear valid; wins over a same-cycle fill
// ---------------------------------------------------------------------------
module fsp_word_cache #(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          srst_i,
    input  logic [AW-1:0] lookup_addr_i,
    output logic          hit_o,
    output logic [15:0]   word_o,
    input  logic          fill_en_i,
    input  logic [AW-1:0] fill_addr_i,
    input  logic [15:0]   fill_data_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          wr_lane_i,
    input  logic [7:0]    wr_byte_i,
    input  logic          inval_i
);

    logic [AW-1:0] tag_q;
    logic [15:0]   word_q;
    logic [15:0]   word_d;
    logic          valid_q;
    logic          wr_match;

    assign hit_o    = valid_q && (tag_q == lookup_addr_i);
    assign word_o   = word_q;
    assign wr_match = wr_en_i && (tag_q == wr_addr_i);

    // Per-lane merge: a fill replaces the whole word, a matching write
    // replaces only its own lane.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            always_comb begin
                word_d[gi*8 +: 8] = word_q[gi*8 +: 8];
                if (fill_en_i) begin
                    word_d[gi*8 +: 8] = fill_data_i[gi*8 +: 8];
                end else if (wr_match && (wr_lane_i == 1'(gi))) begin
                    word_d[gi*8 +: 8] = wr_byte_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst_i) begin
            tag_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q <= word_d;
            if (fill_en_i) begin
                tag_q   <= fill_addr_i;
                valid_q <= 1'b1;
            end
            if (inval_i) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/floppy_sdram_port.sv
// ---------------------------------------------------------------------------
// floppy_sdram_port
// Responder for the floppy subsystem's byte-wide SDRAM window. Single-byte
// rd/wr strobes are serviced on a 16-bit word port of the SDRAM controller;
// completion is reported by busy falling.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   addr, wdata, rd, wr : requester strobe side (sampled on the strobe cycle)
//   rdata, busy         : read byte (held until next read completes), busy
//   mem_addr/wdata/be/we/req, mem_ack : controller request side
//   mem_rdata, mem_rvalid           : controller read return
//   cache_inval         : another master wrote SDRAM
// Build option: define FLOPPY_SDRAM_WCACHE_EN to add a one-word read cache.
// Without it every read goes to SDRAM and cache_inval is ignored.
// ---------------------------------------------------------------------------
module floppy_sdram_port
    import floppy_pkg::*;
#(
    parameter int ADDR_WIDTH = 23,
    parameter int MEM_AW     = 22
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    input  logic                  rd,
    input  logic                  wr,
    output logic [7:0]            rdata,
    output logic                  busy,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [15:0]           mem_wdata,
    output logic [1:0]            mem_be,
    output logic                  mem_we,
    output logic                  mem_req,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_rvalid,
    input  logic                  cache_inval
);

    fsp_state_e        state_q;
    logic              lane_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [1:0]        mem_be_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [15:0]       mem_wdata_q;
    logic [7:0]        rdata_q;

    logic [MEM_AW-1:0] word_addr;
    logic              idle;
    logic              cache_hit;
    logic [15:0]       cache_word;

    assign word_addr = addr[ADDR_WIDTH-1:1];
    assign idle      = (state_q == FSP_IDLE);

`ifdef FLOPPY_SDRAM_WCACHE_EN
    fsp_word_cache #(
        .AW (MEM_AW)
    ) u_cache (
        .clk           (clk),
        .srst_i        (reset),
        .lookup_addr_i (word_addr),
        .hit_o         (cache_hit),
        .word_o        (cache_word),
        .fill_en_i     ((state_q == FSP_RWAIT) && mem_rvalid),
        .fill_addr_i   (mem_addr_q),
        .fill_data_i   (mem_rdata),
        .wr_en_i       (idle && wr),
        .wr_addr_i     (word_addr),
        .wr_lane_i     (addr[0]),
        .wr_byte_i     (wdata),
        .inval_i       (cache_inval)
    );
`else
    logic unused_cache_inval;
    assign unused_cache_inval = cache_inval;
    assign cache_hit  = 1'b0;
    assign cache_word = 16'h0000;
`endif

    // Combinational on the strobe so the requester sees busy on its own
    // strobe cycle.
    assign busy      = rd | wr | !idle;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FSP_IDLE;
            lane_q      <= LANE_LO;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= BE_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'h0000;
            rdata_q     <= 8'h00;
        end else begin
            case (state_q)
                FSP_IDLE: begin
                    // wr has priority, so rd+wr together is a write
                    if (wr) begin
                        lane_q      <= addr[0];
                        mem_addr_q  <= word_addr;
                        mem_wdata_q <= {wdata, wdata};
                        mem_we_q    <= 1'b1;
                        mem_be_q    <= lane_be(addr[0]);
                        mem_req_q   <= 1'b1;
                        state_q     <= FSP_REQ;
                    end else if (rd) begin
                        lane_q <= addr[0];
                        if (cache_hit) begin
                            state_q <= FSP_HIT;
                        end else begin
                            mem_addr_q <= word_addr;
                            mem_we_q   <= 1'b0;
                            mem_be_q   <= BE_BOTH;
                            mem_req_q  <= 1'b1;
                            state_q    <= FSP_REQ;
                        end
                    end
                end
                FSP_REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= mem_we_q ? FSP_IDLE : FSP_RWAIT;
                    end
                end
                FSP_RWAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= lane_byte(mem_rdata, lane_q);
                        state_q <= FSP_IDLE;
                    end
                end
                FSP_HIT: begin
                    rdata_q <= lane_byte(cache_word, lane_q);
                    state_q <= FSP_IDLE;
                end
                default: state_q <= FSP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_floppy_sdram_port.sv
// ---------------------------------------------------------------------------
// tb_floppy_sdram_port
// Table-driven bench for floppy_sdram_port with a behavioural SDRAM
// controller (programmable ack / rvalid delays, word memory model) and a
// scoreboard queue of expected controller requests. Expectations adapt to
// FLOPPY_SDRAM_WCACHE_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_floppy_sdram_port;

`ifdef FLOPPY_SDRAM_WCACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] addr;
    logic [7:0]  wdata;
    logic        rd, wr;
    logic [7:0]  rdata;
    logic        busy;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_we, mem_req;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        cache_inval;

    always #5 clk = ~clk;

    floppy_sdram_port #(.ADDR_WIDTH(23), .MEM_AW(22)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rd(rd), .wr(wr),
        .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .cache_inval(cache_inval)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // ---------------- controller model + request scoreboard ----------------
    typedef struct {
        logic [21:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic        we;
    } mreq_t;

    mreq_t       exp_q[$];
    logic [15:0] mem_model [logic [21:0]];
    int          cur_ack_dly = 0;
    int          cur_rv_dly  = 1;
    int          req_count   = 0;

    initial begin : responder
        bit          in_req = 1'b0;
        int          ack_cnt = 0;
        int          rv_cnt = 0;
        logic [15:0] rv_word = 16'h0;
        mreq_t       cur;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0;
        forever begin
            @(negedge clk);
            mem_ack    = 1'b0;
            mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rv_word;
                end
            end
            if (mem_req && !in_req && !reset) begin
                in_req  = 1'b1;
                ack_cnt = cur_ack_dly;
                req_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 32'(mem_addr), 32'hFFFF_FFFF);
                    cur = '{addr: mem_addr, be: mem_be, wdata: mem_wdata, we: mem_we};
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            if (in_req) begin
                // every REQ cycle: the request must match and stay stable
                check("req_addr", 32'(mem_addr), 32'(cur.addr));
                check("req_be",   32'(mem_be),   32'(cur.be));
                check("req_we",   32'(mem_we),   32'(cur.we));
                if (cur.we) check("req_wdata", 32'(mem_wdata), 32'(cur.wdata));
                if (ack_cnt == 0) begin
                    mem_ack = 1'b1;
                    in_req  = 1'b0;
                    if (mem_we) begin
                        logic [15:0] w;
                        w = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 16'h0000;
                        if (mem_be[0]) w[7:0]  = mem_wdata[7:0];
                        if (mem_be[1]) w[15:8] = mem_wdata[15:8];
                        mem_model[mem_addr] = w;
                    end else begin
                        rv_word = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 16'h0000;
                        rv_cnt  = cur_rv_dly;
                    end
                end else begin
                    ack_cnt--;
                end
            end
        end
    end

    // ---------------- one requester transaction ----------------
    // viol_at > 0: drive an illegal rd strobe (other address) that many
    // cycles after the real strobe; latched request must not change.
    task automatic do_op(input string name, input logic do_rd, input logic do_wr,
                         input logic [22:0] a, input logic [7:0] d,
                         input int ack_dly, input int rv_dly,
                         input int exp_busy, input int exp_req,
                         input logic [7:0] exp_rdata, input int viol_at);
        int   n;
        int   req0;
        logic [7:0] exp_rd[$];
        @(negedge clk);
        cur_ack_dly = ack_dly;
        cur_rv_dly  = rv_dly;
        if (exp_req != 0) begin
            if (do_wr)
                exp_q.push_back('{addr: a[22:1], be: (a[0] ? 2'b10 : 2'b01),
                                  wdata: {d, d}, we: 1'b1});
            else
                exp_q.push_back('{addr: a[22:1], be: 2'b11, wdata: 16'h0, we: 1'b0});
        end
        if (!do_wr) exp_rd.push_back(exp_rdata);
        req0  = req_count;
        addr  = a;
        wdata = d;
        rd    = do_rd;
        wr    = do_wr;
        #1 check({name, "_busy_on_strobe"}, 32'(busy), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == viol_at && viol_at > 0) begin
                rd   = 1'b1;
                addr = 23'h000040;
            end else begin
                rd = 1'b0;
                wr = 1'b0;
            end
            #1;
            if (viol_at > 0 && n == viol_at + 1)
                check({name, "_addr_hold"}, 32'(mem_addr), 32'(a[22:1]));
        end while (busy && n < 200);
        check({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        check({name, "_req_count"}, 32'(req_count - req0), 32'(exp_req));
        if (exp_rd.size() != 0)
            check({name, "_rdata"}, 32'(rdata), 32'(exp_rd.pop_front()));
    endtask

    typedef struct {
        logic        is_wr;
        logic [22:0] addr;
        logic [7:0]  wdata;
        int          ack_dly;
        int          rv_dly;
        logic [7:0]  exp_rdata;
        int          busy_nc, req_nc;   // expectations without cache
        int          busy_c,  req_c;    // expectations with cache
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        do_op($sformatf("vec%0d", i), !v.is_wr, v.is_wr, v.addr, v.wdata,
              v.ack_dly, v.rv_dly,
              CACHE_ON ? v.busy_c : v.busy_nc, CACHE_ON ? v.req_c : v.req_nc,
              v.exp_rdata, 0);
    endtask

    initial begin
        //         wr    addr        wd     A  R  rdata  busy/req nc  busy/req c
        vecs[0] = '{1'b1, 23'h012345, 8'hA5, 3, 1, 8'h00, 5, 1, 5, 1};
        vecs[1] = '{1'b0, 23'h000010, 8'h00, 1, 2, 8'hEF, 5, 1, 5, 1};
        vecs[2] = '{1'b0, 23'h000011, 8'h00, 1, 2, 8'hBE, 5, 1, 2, 0};
        vecs[3] = '{1'b1, 23'h000011, 8'h55, 0, 1, 8'h00, 2, 1, 2, 1};
        vecs[4] = '{1'b0, 23'h000011, 8'h00, 1, 2, 8'h55, 5, 1, 2, 0};
        vecs[5] = '{1'b0, 23'h000010, 8'h00, 1, 2, 8'hEF, 5, 1, 2, 0};
        vecs[6] = '{1'b0, 23'h012345, 8'h00, 2, 1, 8'hA5, 5, 1, 5, 1};
        vecs[7] = '{1'b0, 23'h012344, 8'h00, 0, 1, 8'h00, 3, 1, 2, 0};
        mem_model[22'h000008] = 16'hBEEF;

        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; cache_inval = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_be",    32'(mem_be),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata",     32'(rdata),     32'd0);

        for (int i = 0; i < 6; i++) run_vec(i);

        // invalidate, then the previously cached word must miss
        @(negedge clk);
        cache_inval = 1'b1;
        @(negedge clk);
        cache_inval = 1'b0;
        do_op("inval_rd", 1'b1, 1'b0, 23'h000011, 8'h00, 1, 2, 5, 1, 8'h55, 0);

        for (int i = 6; i < 8; i++) run_vec(i);

        // rd+wr together is a write (low lane)
        do_op("rdwr_both", 1'b1, 1'b1, 23'h000020, 8'h3C, 0, 1, 2, 1, 8'h00, 0);
        do_op("rdwr_back", 1'b1, 1'b0, 23'h000020, 8'h00, 0, 1, 3, 1, 8'h3C, 0);

        // second strobe during REQ is ignored
        do_op("viol_req", 1'b0, 1'b1, 23'h000030, 8'h11, 3, 1, 5, 1, 8'h00, 2);

        // reset while in RWAIT, with the read data arriving afterwards
        @(negedge clk);
        cur_ack_dly = 0;
        cur_rv_dly  = 5;
        exp_q.push_back('{addr: 22'h000008, be: 2'b11, wdata: 16'h0, we: 1'b0});
        addr = 23'h000010;
        rd   = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_busy",    32'(busy),    32'd0);
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_rdata",   32'(rdata),   32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("stray_rv_rdata", 32'(rdata), 32'd0);
        check("stray_rv_busy",  32'(busy),  32'd0);
        do_op("post_rst_rd", 1'b1, 1'b0, 23'h000010, 8'h00, 1, 2, 5, 1, 8'hEF, 0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
